alu_muldiv_seq: RTL and testbench
=================================

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  request, sampled only when busy=0.
REQ-004 SHALL have ports: op_sel  in  1  0=multiply, 1=divide.
REQ-005 SHALL have ports: op_a  in  16  multiplicand or dividend.
REQ-006 SHALL have ports: op_b  in  16  multiplier or divisor.
REQ-007 SHALL have ports: alu_a, alu_b  out  16 each  shared-ALU operands.
REQ-008 SHALL have ports: alu_ctrl  out  3  ALU opcode (000 ADD, 001 SUB, 111 unsigned SLT).
REQ-009 SHALL have ports: alu_result  in  16  combinational ALU result.
REQ-010 SHALL have ports: busy  out  1  operation in progress.
REQ-011 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports: result_lo  out  16  product[15:0] or quotient.
REQ-013 SHALL have ports: result_hi  out  16  remainder (divide), 0 (multiply).
REQ-014 SHALL have ports: div_by_zero, ill_op  out  1 each  status flags.

Function
REQ-015 SHALL implement states IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE; busy=1 in every state except IDLE and DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start while busy=1 is ignored, with no effect on state or outputs.
REQ-017 On accept, SHALL clear result_lo, result_hi and flags, latch operands, clear the 5-bit step counter, and go to MUL_STEP (op_sel=0) or DIV_CMP (op_sel=1).
REQ-018 MUL_STEP: SHALL drive alu_a=acc, alu_b=mcand, alu_ctrl=ADD; acc<=alu_result only if mplier[0]=1; mcand<<=1, mplier>>=1 every cycle; after 16 steps -> DONE.
REQ-019 Product SHALL be truncated mod 2^16; done SHALL assert in the 17th cycle after the accepting edge.
REQ-020 DIV_CMP: SHALL form 17-bit rem_s={rem[15:0],quo[15]}, drive alu_a=rem_s[15:0], alu_b=divisor, alu_ctrl=SLT; register rem<=rem_s, quo<<=1, and lt<=(rem_s[16] ? 0 : alu_result[0]); then -> DIV_SUB.
REQ-021 DIV_SUB: SHALL drive alu_a=rem[15:0], alu_b=divisor, alu_ctrl=SUB; if lt=0, rem<=alu_result (bit 16 cleared) and quo[0]<=1; after 16 bits -> DONE; done SHALL assert in the 33rd cycle.
REQ-022 Divisor=0 SHALL skip iteration: go to DONE next cycle with result_lo=0xFFFF, result_hi=dividend, div_by_zero=1.
REQ-023 When not busy, SHALL drive alu_a=0, alu_b=0, alu_ctrl=000.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE; results and flags SHALL hold until the next accepted start or reset.
REQ-025 A start in DONE SHALL be accepted; done still pulses that cycle.

Reset
REQ-026 rst=1 at any time, including mid-operation, SHALL on that edge force IDLE and zero every output and internal register; an in-flight operation SHALL be abandoned with no done.
REQ-027 rst SHALL take priority over start on the same edge.

Configuration
REQ-028 With MULDIV_DIV_EN defined, SHALL implement divide per REQ-020..022.
REQ-029 Without MULDIV_DIV_EN, DIV_CMP/DIV_SUB logic SHALL be absent; start with op_sel=1 SHALL go to DONE next cycle with ill_op=1 and results=0; div_by_zero SHALL be tied 0.

Structure
REQ-030 SHALL take ALU opcode constants (ADD/SUB/SLT), state encoding and WIDTH=16 from shared package muldiv_pkg.
REQ-031 SHALL be a single module with no sub-module; the counter, FSM and datapath registers are inline.

Verification
REQ-032 MUL 7x9 -> result_lo=63, result_hi=0, done in cycle 17 only.
REQ-033 MUL 0x0100x0x0100 -> result_lo=0x0000; MUL 0xFFFFx0x0002 -> 0xFFFE.
REQ-034 DIV 100/7 -> q=14, r=2, done cycle 33; DIV 0xFFFF/0x8001 -> q=1, r=0x7FFE.
REQ-035 DIV 5/0 -> result_lo=0xFFFF, result_hi=5, div_by_zero=1, done cycle 1; without MULDIV_DIV_EN -> ill_op=1, results 0.
REQ-036 start pulsed at cycle 5 of a MUL -> ignored, result 63 unaffected; rst at cycle 10 -> all outputs 0, no done, next start works normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Provides the datapath width, the opcodes understood by the external
// shared ALU, and the FSM state encoding.
package muldiv_pkg;

  localparam int WIDTH = 16;

  // Opcodes presented on alu_ctrl to the external shared ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;  // unsigned set-less-than

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_STEP = 3'd1,
    S_DIV_CMP  = 3'd2,
    S_DIV_SUB  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Sequential 16-bit multiply / divide unit that borrows an external ALU.
// Multiply is shift-and-add (16 steps); divide is restoring division with
// one compare cycle and one subtract cycle per quotient bit (32 cycles).
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it a
// divide request completes in one cycle with ill_op=1 and zero results, and
// div_by_zero is tied low.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op_sel       request (0=mul, 1=div), accepted only when not busy
//   op_a, op_b          multiplicand/dividend, multiplier/divisor
//   alu_a, alu_b        operands driven to the shared ALU (0 when idle)
//   alu_ctrl            ALU opcode (ADD / SUB / SLT)
//   alu_result          combinational ALU result
//   busy, done          operation in progress, one-cycle completion pulse
//   result_lo/hi        product[15:0] or quotient / remainder (0 for mul)
//   div_by_zero, ill_op status flags, held with the results
//
// Handshake: start is sampled on a rising edge only while busy=0 (state
// IDLE or DONE); a start seen while busy=1 is dropped without effect.
// done is high for exactly the one cycle the FSM spends in DONE, and
// results/flags stay valid from then until the next accepted start.
module alu_muldiv_seq
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             ill_op
);

  state_t           state, state_next, start_target;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [4:0]       cnt;
  logic             accept;
  logic             last_step;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             lt;
  logic [WIDTH:0]   rem_s;
  // Shift the next dividend bit into the partial remainder.
  assign rem_s = {rem, quo[WIDTH-1]};
`endif

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last_step = (cnt == 5'd15);

  // Where an accepted start leads.
  always_comb begin
    start_target = S_MUL_STEP;
    if (op_sel) begin
`ifdef MULDIV_DIV_EN
      start_target = (op_b == '0) ? S_DONE : S_DIV_CMP;
`else
      start_target = S_DONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = ALU_ADD;
    case (state)
      S_IDLE: begin
        if (start) state_next = start_target;
      end
      S_MUL_STEP: begin
        busy     = 1'b1;
        alu_a    = acc;
        alu_b    = mcand;
        alu_ctrl = ALU_ADD;
        if (last_step) state_next = S_DONE;
      end
`ifdef MULDIV_DIV_EN
      S_DIV_CMP: begin
        busy       = 1'b1;
        alu_a      = rem_s[WIDTH-1:0];
        alu_b      = divisor;
        alu_ctrl   = ALU_SLT;
        state_next = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        busy       = 1'b1;
        alu_a      = rem;
        alu_b      = divisor;
        alu_ctrl   = ALU_SUB;
        state_next = last_step ? S_DONE : S_DIV_CMP;
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        state_next = start ? start_target : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      ill_op    <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      lt          <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else if (accept) begin
      acc       <= '0;
      mcand     <= op_a;
      mplier    <= op_b;
      cnt       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      ill_op    <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem         <= '0;
      quo         <= op_a;
      divisor     <= op_b;
      lt          <= 1'b0;
      div_by_zero <= 1'b0;
      if (op_sel && op_b == '0) begin
        result_lo   <= '1;
        result_hi   <= op_a;
        div_by_zero <= 1'b1;
      end
`else
      ill_op <= op_sel;
`endif
    end else begin
      case (state)
        S_MUL_STEP: begin
          if (mplier[0]) acc <= alu_result;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + 5'd1;
          if (last_step) result_lo <= mplier[0] ? alu_result : acc;
        end
`ifdef MULDIV_DIV_EN
        S_DIV_CMP: begin
          rem <= rem_s[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
          // A carried-out bit 16 means the remainder already exceeds any divisor.
          lt  <= rem_s[WIDTH] ? 1'b0 : alu_result[0];
        end
        S_DIV_SUB: begin
          cnt <= cnt + 5'd1;
          if (!lt) begin
            rem    <= alu_result;
            quo[0] <= 1'b1;
          end
          if (last_step) begin
            result_lo <= {quo[WIDTH-1:1], ~lt};
            result_hi <= lt ? rem : alu_result;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef MULDIV_DIV_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq. Provides a behavioural model of the
// external shared ALU, drives operations and checks results, done timing,
// start-while-busy rejection, mid-operation reset and start in DONE.
// Divide expectations follow whether MULDIV_DIV_EN is defined.
module tb_alu_muldiv_seq;

  logic        clk, rst, start, op_sel;
  logic [15:0] op_a, op_b, alu_a, alu_b, alu_result, result_lo, result_hi;
  logic [2:0]  alu_ctrl;
  logic        busy, done, div_by_zero, ill_op;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .busy(busy),
    .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .ill_op(ill_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external ALU model
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = {15'd0, (alu_a < alu_b)};
      default: alu_result = 16'd0;
    endcase
  end

  // Drives one operation (accepted on the first rising edge) and watches
  // up to 70 cycles. Cycle n is the n-th cycle after the accepting edge.
  // Optionally pulses start (with the second operand set) or rst during a
  // given cycle, and snapshots busy/result_lo during another.
  task automatic run_op(input logic sel, input logic [15:0] a, input logic [15:0] b,
                        input int again_cyc, input logic sel2,
                        input logic [15:0] a2, input logic [15:0] b2,
                        input int rst_cyc, input int snap_cyc,
                        output int first_done, output int last_done, output int n_done,
                        output logic snap_busy, output logic [15:0] snap_lo);
    first_done = 0; last_done = 0; n_done = 0; snap_busy = 1'b0; snap_lo = 16'h0;
    @(negedge clk);
    start = 1'b1; op_sel = sel; op_a = a; op_b = b;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (n_done == 0) first_done = cyc;
        last_done = cyc;
        n_done++;
      end
      if (cyc == snap_cyc) begin
        snap_busy = busy;
        snap_lo   = result_lo;
      end
      start = (cyc == again_cyc);
      if (cyc == again_cyc) begin
        op_sel = sel2; op_a = a2; op_b = b2;
      end
      rst = (cyc == rst_cyc);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_sel = 1'b0; op_a = 16'h0; op_b = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, ill_op} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b, want 0000", {busy, done, div_by_zero, ill_op});
    end
    checks++;
    if ({result_lo, result_hi} !== 32'h0) begin
      errors++; $display("FAIL reset_results: got %h, want 0", {result_lo, result_hi});
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 35'h0) begin
      errors++; $display("FAIL reset_alu: got a=%h b=%h ctrl=%b, want 0", alu_a, alu_b, alu_ctrl);
    end
  endtask

  task automatic test_mul();
    int fd, ld, nd; logic sb; logic [15:0] sl;
    run_op(1'b0, 16'd7, 16'd9, 0, 1'b0, 16'h0, 16'h0, 0, 1, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'd63 || result_hi !== 16'd0) begin
      errors++; $display("FAIL mul_7x9: got lo=%0d hi=%0d, want 63 0", result_lo, result_hi);
    end
    checks++;
    if (fd !== 17 || nd !== 1) begin
      errors++; $display("FAIL mul_done_timing: got cycle=%0d pulses=%0d, want 17 1", fd, nd);
    end
    checks++;
    if (sb !== 1'b1 || sl !== 16'h0) begin
      errors++; $display("FAIL mul_busy: got busy=%b lo=%h at cycle 1, want 1 0000", sb, sl);
    end
    checks++;
    if ({busy, div_by_zero, ill_op} !== 3'b000) begin
      errors++; $display("FAIL mul_flags: got %b, want 000", {busy, div_by_zero, ill_op});
    end
    run_op(1'b0, 16'h0100, 16'h0100, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'h0000 || result_hi !== 16'h0) begin
      errors++; $display("FAIL mul_wrap: got lo=%h hi=%h, want 0000 0000", result_lo, result_hi);
    end
    run_op(1'b0, 16'hFFFF, 16'h0002, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'hFFFE) begin
      errors++; $display("FAIL mul_ffff_x2: got %h, want fffe", result_lo);
    end
    run_op(1'b0, 16'd1234, 16'd0, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'd0 || fd !== 17) begin
      errors++; $display("FAIL mul_by_zero: got lo=%0d cycle=%0d, want 0 17", result_lo, fd);
    end
  endtask

  task automatic test_div();
    int fd, ld, nd; logic sb; logic [15:0] sl;
`ifdef MULDIV_DIV_EN
    run_op(1'b1, 16'd100, 16'd7, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'd14 || result_hi !== 16'd2) begin
      errors++; $display("FAIL div_100_7: got q=%0d r=%0d, want 14 2", result_lo, result_hi);
    end
    checks++;
    if (fd !== 33 || nd !== 1) begin
      errors++; $display("FAIL div_done_timing: got cycle=%0d pulses=%0d, want 33 1", fd, nd);
    end
    run_op(1'b1, 16'hFFFF, 16'h8001, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'h0001 || result_hi !== 16'h7FFE) begin
      errors++; $display("FAIL div_ffff_8001: got q=%h r=%h, want 0001 7ffe", result_lo, result_hi);
    end
    run_op(1'b1, 16'd5, 16'd0, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'hFFFF || result_hi !== 16'd5 || div_by_zero !== 1'b1 || fd !== 1) begin
      errors++; $display("FAIL div_by_zero: got lo=%h hi=%h dbz=%b cycle=%0d, want ffff 0005 1 1",
                         result_lo, result_hi, div_by_zero, fd);
    end
`else
    run_op(1'b1, 16'd100, 16'd7, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (ill_op !== 1'b1 || result_lo !== 16'h0 || result_hi !== 16'h0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div_illegal: got ill=%b lo=%h hi=%h dbz=%b, want 1 0 0 0",
                         ill_op, result_lo, result_hi, div_by_zero);
    end
    checks++;
    if (fd !== 1 || nd !== 1) begin
      errors++; $display("FAIL div_illegal_timing: got cycle=%0d pulses=%0d, want 1 1", fd, nd);
    end
    run_op(1'b1, 16'd5, 16'd0, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (ill_op !== 1'b1 || result_lo !== 16'h0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div0_illegal: got ill=%b lo=%h dbz=%b, want 1 0 0", ill_op, result_lo, div_by_zero);
    end
`endif
    // A following multiply clears the flags.
    run_op(1'b0, 16'd2, 16'd3, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'd6 || ill_op !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL flags_clear: got lo=%0d ill=%b dbz=%b, want 6 0 0", result_lo, ill_op, div_by_zero);
    end
  endtask

  task automatic test_start_ignored();
    int fd, ld, nd; logic sb; logic [15:0] sl;
    run_op(1'b0, 16'd7, 16'd9, 5, 1'b0, 16'd3, 16'd3, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'd63 || fd !== 17 || nd !== 1) begin
      errors++; $display("FAIL start_ignored: got lo=%0d cycle=%0d pulses=%0d, want 63 17 1", result_lo, fd, nd);
    end
  endtask

  task automatic test_mid_reset();
    int fd, ld, nd; logic sb; logic [15:0] sl;
    run_op(1'b0, 16'd7, 16'd9, 0, 1'b0, 16'h0, 16'h0, 10, 11, fd, ld, nd, sb, sl);
    checks++;
    if (nd !== 0 || sb !== 1'b0) begin
      errors++; $display("FAIL mid_reset_abort: got pulses=%0d busy=%b, want 0 0", nd, sb);
    end
    checks++;
    if ({result_lo, result_hi, alu_a, alu_b} !== 64'h0 || {alu_ctrl, busy, done, div_by_zero, ill_op} !== 7'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got lo=%h hi=%h a=%h b=%h ctrl=%b, want all 0",
                         result_lo, result_hi, alu_a, alu_b, alu_ctrl);
    end
    run_op(1'b0, 16'd7, 16'd9, 0, 1'b0, 16'h0, 16'h0, 0, 0, fd, ld, nd, sb, sl);
    checks++;
    if (result_lo !== 16'd63 || fd !== 17) begin
      errors++; $display("FAIL after_reset_mul: got lo=%0d cycle=%0d, want 63 17", result_lo, fd);
    end
  endtask

  task automatic test_back_to_back();
    int fd, ld, nd; logic sb; logic [15:0] sl;
    run_op(1'b0, 16'd7, 16'd9, 17, 1'b0, 16'd3, 16'd5, 0, 20, fd, ld, nd, sb, sl);
    checks++;
    if (nd !== 2 || fd !== 17 || ld !== 34) begin
      errors++; $display("FAIL b2b_timing: got pulses=%0d first=%0d last=%0d, want 2 17 34", nd, fd, ld);
    end
    checks++;
    if (sb !== 1'b1 || sl !== 16'h0) begin
      errors++; $display("FAIL b2b_clear: got busy=%b lo=%h at cycle 20, want 1 0000", sb, sl);
    end
    checks++;
    if (result_lo !== 16'd15) begin
      errors++; $display("FAIL b2b_result: got %0d, want 15", result_lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
